// File: rtl/mfcc_accum_tx.sv
// mfcc_accum_tx: per-lane MFCC product accumulator feeding an AXI4-Stream frame transmitter.
// Optional macro MFCC_ACCUM_TX_SAT_EN saturates stored sums to signed 24 bits.
module mfcc_accum_tx #(
  parameter int NUM_COEF  = 13,
  parameter int FRAME_LEN = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mult_valid,
  input  logic [27:0] mult_p0,
  input  logic [27:0] mult_p1,
  input  logic [27:0] mult_p2,
  input  logic [27:0] mult_p3,
  input  logic [27:0] mult_p4,
  input  logic [27:0] mult_p5,
  input  logic [27:0] mult_p6,
  input  logic [27:0] mult_p7,
  input  logic [27:0] mult_p8,
  input  logic [27:0] mult_p9,
  input  logic [27:0] mult_p10,
  input  logic [27:0] mult_p11,
  input  logic [27:0] mult_p12,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        overrun
);
  localparam int BW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam int IW = NUM_COEF > 1 ? $clog2(NUM_COEF) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic overrun_q, overrun_d;
  logic [27:0] prod [13];
  logic [31:0] acc_q [NUM_COEF];
  logic [31:0] sum [NUM_COEF];
  logic [31:0] buf_q [NUM_COEF];
  logic frame_done, last, hs, load;
  function automatic logic [31:0] clip(input logic signed [31:0] s);
`ifdef MFCC_ACCUM_TX_SAT_EN
    return s > 32'sd8388607 ? 32'sd8388607 : s < -32'sd8388608 ? -32'sd8388608 : s;
`else
    return s;
`endif
  endfunction
  assign prod = '{mult_p0, mult_p1, mult_p2, mult_p3, mult_p4, mult_p5, mult_p6,
                  mult_p7, mult_p8, mult_p9, mult_p10, mult_p11, mult_p12};
  for (genvar k = 0; k < NUM_COEF; k++) begin : g_sum
    assign sum[k] = acc_q[k] + {{4{prod[k][27]}}, prod[k]};
  end
  assign frame_done = mult_valid && beat_q == BW'(FRAME_LEN - 1);
  assign last       = state_q == SEND && idx_q == IW'(NUM_COEF - 1);
  assign hs         = state_q == SEND && m_tready;
  // A frame lands in the buffer only if nothing is pending or the final beat leaves this cycle
  assign load       = frame_done && (state_q == IDLE || (last && m_tready));
  always_comb begin
    state_d   = load ? SEND : (hs && last) ? IDLE : state_q;
    idx_d     = (load || (hs && last)) ? '0 : hs ? idx_q + IW'(1) : idx_q;
    beat_d    = !mult_valid ? beat_q : frame_done ? '0 : beat_q + BW'(1);
    overrun_d = overrun_q | (frame_done & ~load);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_COEF; k++) begin
        acc_q[k] <= '0;
        buf_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < NUM_COEF; k++) begin
        if (mult_valid) acc_q[k] <= frame_done ? '0 : sum[k];
        if (load) buf_q[k] <= clip(sum[k]);
      end
    end
  end
  assign m_tvalid = state_q == SEND;
  assign m_tlast  = last;
  assign m_tdata  = m_tvalid ? buf_q[idx_q] : '0;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_mfcc_accum_tx.sv
// tb_mfcc_accum_tx: directed self-checking bench for mfcc_accum_tx.
module tb_mfcc_accum_tx;
  logic clk = 1'b0, resetn = 1'b0, mult_valid = 1'b0, m_tready = 1'b0;
  logic [27:0] p [13];
  logic [31:0] m_tdata;
  logic m_tvalid, m_tlast, overrun;
  int errors = 0, checks = 0, unstable = 0;
  int got[$];
  bit lq[$];
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  mfcc_accum_tx dut (
    .clk(clk), .resetn(resetn), .mult_valid(mult_valid),
    .mult_p0(p[0]), .mult_p1(p[1]), .mult_p2(p[2]), .mult_p3(p[3]), .mult_p4(p[4]),
    .mult_p5(p[5]), .mult_p6(p[6]), .mult_p7(p[7]), .mult_p8(p[8]), .mult_p9(p[9]),
    .mult_p10(p[10]), .mult_p11(p[11]), .mult_p12(p[12]),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .overrun(overrun)
  );

  // One clock: apply inputs, observe at the falling edge, return 1 time unit after the rising edge
  task automatic cycle(input logic v, input logic r);
    mult_valid = v;
    m_tready = r;
    @(negedge clk);
    if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last)) unstable++;
    prev_stall = m_tvalid && !m_tready;
    prev_data = m_tdata;
    prev_last = m_tlast;
    if (m_tvalid && m_tready) begin
      got.push_back(int'(m_tdata));
      lq.push_back(m_tlast);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < 13; k++) p[k] = 28'(v);
  endtask

  task automatic clear_log();
    got.delete();
    lq.delete();
    unstable = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mult_valid = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    mult_valid = 1'b1;
    set_all(5);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
    checks++; if (m_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata got=%0d exp=0", m_tdata); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    mult_valid = 1'b0;
    resetn = 1'b1;
    clear_log();
    repeat (3) cycle(1'b0, 1'b1);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_basic();
    clear_log();
    set_all(1000);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b1);
      if (i == 13) begin
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", m_tvalid); end
      end
    end
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", m_tvalid); end
    checks++; if (m_tdata !== 32'd15000) begin errors++; $display("FAIL basic_first got=%0d exp=15000", m_tdata); end
    repeat (16) cycle(1'b0, 1'b1);
    checks++; if (got.size() != 13) begin errors++; $display("FAIL basic_count got=%0d exp=13", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 15000 || lq[i] !== (i == 12)) begin errors++; $display("FAIL basic_beat%0d got=%0d/%b exp=15000/%b", i, got[i], lq[i], i == 12); end
    end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_stall();
    clear_log();
    for (int k = 0; k < 13; k++) p[k] = 28'(-(k + 1));
    for (int i = 0; i < 15; i++) cycle(1'b1, i[0]);
    for (int i = 0; i < 40; i++) cycle(1'b0, i[0] == 1'b0);
    checks++; if (got.size() != 13) begin errors++; $display("FAIL stall_count got=%0d exp=13", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== -15 * (i + 1) || lq[i] !== (i == 12)) begin errors++; $display("FAIL stall_beat%0d got=%0d/%b exp=%0d/%b", i, got[i], lq[i], -15 * (i + 1), i == 12); end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int k = 0; k < 13; k++) p[k] = 28'(k + 1);
    for (int i = 0; i < 30; i++) begin
      if (i == 15) set_all(100);
      cycle(1'b1, 1'b0);
      if (i == 28) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got=%b exp=0", overrun); end
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    checks++; if (m_tdata !== 32'd15) begin errors++; $display("FAIL overrun_hold got=%0d exp=15", m_tdata); end
    repeat (20) cycle(1'b0, 1'b1);
    checks++; if (got.size() != 13) begin errors++; $display("FAIL overrun_count got=%0d exp=13", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 15 * (i + 1)) begin errors++; $display("FAIL overrun_beat%0d got=%0d exp=%0d", i, got[i], 15 * (i + 1)); end
    end
    checks++; if (overrun !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL overrun_sticky got=%b/%b exp=1/0", overrun, m_tvalid); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    do_reset();
    for (int c = 1; c <= 45; c++) begin
      if (c >= 16 && c <= 43 && m_tvalid !== 1'b1) gaps++;
      set_all(c <= 15 ? 3 : 5);
      cycle(c <= 30, c >= 18);
    end
    checks++; if (got.size() != 26) begin errors++; $display("FAIL b2b_count got=%0d exp=26", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== (i < 13 ? 45 : 75) || lq[i] !== (i == 12 || i == 25)) begin errors++; $display("FAIL b2b_beat%0d got=%0d/%b exp=%0d/%b", i, got[i], lq[i], i < 13 ? 45 : 75, i == 12 || i == 25); end
    end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gap got=%0d exp=0", gaps); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_saturation();
    int pos, neg;
`ifdef MFCC_ACCUM_TX_SAT_EN
    pos = 32'h007FFFFF;
    neg = 32'hFF800000;
`else
    pos = 32'h07800000;
    neg = 32'hF8800000;
`endif
    do_reset();
    for (int k = 0; k < 13; k++) p[k] = 28'(k[0] ? -(1 << 23) : (1 << 23));
    repeat (15) cycle(1'b1, 1'b1);
    repeat (15) cycle(1'b0, 1'b1);
    checks++; if (got.size() != 13) begin errors++; $display("FAIL sat_count got=%0d exp=13", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== (i[0] ? neg : pos)) begin errors++; $display("FAIL sat_beat%0d got=%h exp=%h", i, got[i], i[0] ? neg : pos); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_all(9);
    repeat (7) cycle(1'b1, 1'b1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_out got=%b/%b exp=0/0", m_tvalid, overrun); end
    resetn = 1'b1;
    clear_log();
    set_all(2);
    repeat (15) cycle(1'b1, 1'b1);
    repeat (15) cycle(1'b0, 1'b1);
    checks++; if (got.size() != 13) begin errors++; $display("FAIL midrst_count got=%0d exp=13", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 30) begin errors++; $display("FAIL midrst_beat%0d got=%0d exp=30", i, got[i]); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
  endtask

  initial begin
    set_all(0);
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
